// File: rtl/booth_mult_datapath_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath: default
// operand width, FSM state encoding and width helpers derived from N.
package booth_mult_datapath_pkg;

    // Default operand width and Booth iteration count.
    localparam int N_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Accumulator A carries one extra sign bit so that -M fits when M = -2^(N-1).
    function automatic int acc_width(input int n);
        return n + 1;
    endfunction

    // Signed product width.
    function automatic int prod_width(input int n);
        return 2 * n;
    endfunction

    // Step counter must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of the combined shift register {A, Q, q_m1}.
    function automatic int shift_width(input int n);
        return 2 * n + 2;
    endfunction

    localparam int A_W_DEF   = acc_width(N_DEF);
    localparam int P_W_DEF   = prod_width(N_DEF);
    localparam int CNT_W_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/booth_mult_datapath_booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of the
// sign-extended multiplicand into A, then an arithmetic right shift of
// {A, Q, q_m1} by one bit.
module booth_step
    import booth_mult_datapath_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2*N+1:0] acc_in,   // {A[N:0], Q[N-1:0], q_m1}
    input  logic [N-1:0]   m,
    output logic [2*N+1:0] acc_out
);

    logic [N:0]   a_cur;
    logic [N-1:0] q_cur;
    logic         qm1_cur;
    logic [N:0]   m_ext;
    logic [N:0]   a_sum;

    assign a_cur   = acc_in[2*N+1:N+1];
    assign q_cur   = acc_in[N:1];
    assign qm1_cur = acc_in[0];
    assign m_ext   = {m[N-1], m};

    // Booth recoding of the current bit pair selects +M, -M or no change.
    always_comb begin
        a_sum = a_cur;
        case ({q_cur[0], qm1_cur})
            2'b01:   a_sum = a_cur + m_ext;
            2'b10:   a_sum = a_cur - m_ext;
            default: a_sum = a_cur;
        endcase
    end

    // Arithmetic shift right: A's MSB is replicated, old q_m1 falls off.
    assign acc_out = {a_sum[N], a_sum, q_cur};

endmodule

// File: rtl/booth_mult_datapath.sv
// Sequential radix-2 Booth multiplier datapath. Driven by an external
// iteration controller through start/done; performs one Booth step per clock
// while running, captures the product on done and flags a done that arrives
// before all N steps have executed.
//
// Handshake: start is a level load/restart that wins over everything else;
// done is a level from the controller, acted on only in RUN, and once it
// has been acted on the block waits in HOLD for the next start.
module booth_mult_datapath
    import booth_mult_datapath_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              done,
    input  logic [N-1:0]      multiplicand,
    input  logic [N-1:0]      multiplier,
    output logic [2*N-1:0]    product,
    output logic              prod_valid,
    output logic              seq_err
);

    localparam int A_W   = acc_width(N);
    localparam int CNT_W = cnt_width(N);
    localparam int S_W   = shift_width(N);
    localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(N);

    state_t            state_q;
    state_t            state_d;

    logic [A_W-1:0]    a_q;
    logic [N-1:0]      q_q;
    logic              qm1_q;
    logic [N-1:0]      m_q;
    logic [CNT_W-1:0]  step_cnt;

    logic              do_load;
    logic              do_step;
    logic              do_capture;
    logic              steps_pending;
    logic [S_W-1:0]    step_out;

    assign steps_pending = (step_cnt < STEP_LIMIT);

    booth_step #(.N(N)) u_booth_step (
        .acc_in  ({a_q, q_q, qm1_q}),
        .m       (m_q),
        .acc_out (step_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start restarts from any state, done ends a run.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (done) state_d = HOLD;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath control decoded from state and handshake inputs.
    always_comb begin
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_capture = 1'b0;
        if (start) begin
            do_load = 1'b1;
        end else if (state_q == RUN) begin
            if (done) begin
                do_capture = 1'b1;
            end else if (steps_pending) begin
                do_step = 1'b1;
            end
        end
    end

    // Operand/accumulator registers and step counter (saturates at N).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            step_cnt <= '0;
        end else if (do_load) begin
            a_q      <= '0;
            q_q      <= multiplier;
            qm1_q    <= 1'b0;
            m_q      <= multiplicand;
            step_cnt <= '0;
        end else if (do_step) begin
            {a_q, q_q, qm1_q} <= step_out;
            step_cnt          <= step_cnt + 1'b1;
        end
    end

    // Result capture, one-cycle valid pulse and sticky early-done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product    <= '0;
            prod_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else if (do_load) begin
            prod_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else if (do_capture) begin
            product    <= {a_q[N-1:0], q_q};
            prod_valid <= 1'b1;
            if (steps_pending) begin
                seq_err <= 1'b1;
            end
        end else begin
            prod_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mult_datapath.sv
// Bench for booth_mult_datapath: plays the role of the iteration controller
// (start pulse, done raised a chosen number of edges after start release)
// and checks results against an arithmetic model of Booth multiplication.
module tb_booth_mult_datapath;
    import booth_mult_datapath_pkg::*;

    localparam int N   = N_DEF;
    localparam int P_W = 2 * N;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            done;
    logic [N-1:0]    multiplicand;
    logic [N-1:0]    multiplier;
    logic [P_W-1:0]  product;
    logic            prod_valid;
    logic            seq_err;

    int checks;
    int failures;

    booth_mult_datapath #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .done         (done),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .prod_valid   (prod_valid),
        .seq_err      (seq_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: value of the product register after 'steps' Booth steps.
    // After k steps {A,Q} holds M * signed(q[k-1:0]) scaled by 2^(N-k),
    // with the not-yet-consumed multiplier bits q[N-1:k] below it.
    function automatic logic [P_W-1:0] model_product(input logic [N-1:0] m,
                                                     input logic [N-1:0] q,
                                                     input int steps);
        longint ms;
        longint qlow;
        longint qu;
        longint res;
        ms   = longint'($signed(m));
        qu   = longint'(q);
        qlow = qu & ((longint'(1) << steps) - 1);
        if (((qu >> (steps - 1)) & 1) == 1) qlow = qlow - (longint'(1) << steps);
        res  = ((ms * qlow) << (N - steps)) + (qu >> steps);
        return P_W'(res);
    endfunction

    // One operation: start, release, raise done after k edges, check capture.
    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input int k,
                          input logic [P_W-1:0] exp_prod, input logic exp_err,
                          input string name);
        @(negedge clk);
        start        = 1'b1;
        done         = 1'b0;
        multiplicand = m;
        multiplier   = q;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            checks++;
            if (prod_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s pv_before_done: cycle %0d got %b want 0", name, i, prod_valid);
            end
        end
        done = 1'b1;
        @(negedge clk);
        checks++;
        if (prod_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s pv_pulse: got %b want 1", name, prod_valid);
        end
        checks++;
        if (product !== exp_prod) begin
            failures++;
            $display("FAIL %s product: got %h want %h", name, product, exp_prod);
        end
        checks++;
        if (seq_err !== exp_err) begin
            failures++;
            $display("FAIL %s seq_err: got %b want %b", name, seq_err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (prod_valid !== 1'b0 || seq_err !== exp_err) begin
            failures++;
            $display("FAIL %s after_pulse: pv=%b err=%b want pv=0 err=%b",
                     name, prod_valid, seq_err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (product !== '0 || prod_valid !== 1'b0 || seq_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: product=%h pv=%b err=%b want 0/0/0",
                     product, prod_valid, seq_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(6'sd5, -6'sd3, N + 1, 12'hFF1, 1'b0, "m5_qm3");
    endtask

    task automatic test_corners();
        run_op(6'h20, 6'h20, N + 1, 12'h400, 1'b0, "m-32_q-32");
        run_op(6'd31, 6'h20, N + 1, 12'hC20, 1'b0, "m31_q-32");
        run_op(6'd0, -6'sd17, N + 1, 12'h000, 1'b0, "m0_q-17");
    endtask

    task automatic test_restart();
        @(negedge clk);
        start = 1'b1;
        done  = 1'b0;
        multiplicand = 6'd21;
        multiplier   = 6'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (prod_valid !== 1'b0) begin
                failures++;
                $display("FAIL restart_aborted_pv: got %b want 0", prod_valid);
            end
        end
        run_op(6'd7, 6'd7, N + 1, 12'h031, 1'b0, "restart_7x7");
    endtask

    task automatic test_early_done();
        run_op(6'd3, 6'd3, 4, 12'h024, 1'b1, "early_done");
        done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (seq_err !== 1'b1) begin
                failures++;
                $display("FAIL early_done_sticky: got %b want 1", seq_err);
            end
        end
        run_op(6'd3, 6'd3, N + 1, 12'h009, 1'b0, "after_early_full");
    endtask

    task automatic test_hold_stability();
        logic [P_W-1:0] held;
        run_op(-6'sd9, 6'd11, N + 1, 12'hF9D, 1'b0, "hold_setup");
        held = 12'hF9D;
        for (int i = 0; i < 10; i++) begin
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
            @(negedge clk);
            checks++;
            if (product !== held || prod_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable: cycle %0d product=%h pv=%b want %h/0",
                         i, product, prod_valid, held);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        run_op(6'sd5, -6'sd3, N + 1, 12'hFF1, 1'b0, "pre_reset");
        @(negedge clk);
        start = 1'b1;
        done  = 1'b0;
        multiplicand = 6'd25;
        multiplier   = 6'd19;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (product !== '0 || prod_valid !== 1'b0 || seq_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: product=%h pv=%b err=%b want 0/0/0",
                     product, prod_valid, seq_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (product !== '0 || prod_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: product=%h pv=%b want 0/0", product, prod_valid);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        logic [N-1:0] q;
        int           k;
        int           steps;
        for (int t = 0; t < 30; t++) begin
            m     = N'($urandom);
            q     = N'($urandom);
            k     = (t % 3 == 0) ? $urandom_range(1, N + 3) : N + 1;
            steps = (k < N) ? k : N;
            run_op(m, q, k, model_product(m, q, steps), (k < N), "random");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_corners();
        test_restart();
        test_early_done();
        test_hold_stability();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_datapath.md
Name: booth_mult_datapath

Overview:
- Sequential radix-2 Booth multiplier datapath for two signed N-bit operands.
- Sits directly downstream of the iteration control unit and consumes that unit's `start` and `done`.
  - Each clock between load and completion, it performs one Booth add/subtract-and-shift step.
  - On `done` it captures the 2N-bit signed product and pulses `prod_valid`.
- It also checks the handshake: `done` must not arrive before N steps have executed.

Parameters:
- N, 6, operand width and number of Booth iterations. Must equal the controller's iteration limit.

Ports:
- clk  input  1  rising-edge clock, shared with the control unit
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load/restart. Sampled synchronously here, held at least 1 cycle.
- done  input  1  completion flag from the control unit. Level; stays high until the next start.
- multiplicand  input  N  signed operand M, captured when start=1
- multiplier  input  N  signed operand Q, captured when start=1
- product  output  2N  signed result register. Holds its value until the next capture.
- prod_valid  output  1  one-cycle pulse when product is updated
- seq_err  output  1  sticky handshake error for the current operation

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: product=0, prod_valid=0, seq_err=0.
  - Internal registers: A=0, Q=0, q_m1=0, M=0, step_cnt=0, state=IDLE.
- Registers:
  - A is N+1 bits (sign-extended) so that -M does not overflow when M = -2^(N-1).
  - step_cnt is ceil(log2(N+1)) bits and saturates at N.
- States:
  - IDLE: wait for start.
  - RUN: stepping.
  - HOLD: result captured; wait for next start.
- start=1 in any state (highest priority after reset):
  - Loads M=multiplicand, Q=multiplier, A=0, q_m1=0, step_cnt=0, seq_err=0.
  - Sets prod_valid=0 and state=RUN.
  - product keeps its previous value.
  - A start in the middle of RUN aborts the current operation silently.
- RUN, start=0, done=0, step_cnt<N — one Booth step this edge:
  - {Q[0],q_m1}=01: A'=A+M (M sign-extended to N+1).
  - {Q[0],q_m1}=10: A'=A-M.
  - {Q[0],q_m1}=00 or 11: A'=A.
  - Then arithmetic right shift of {A',Q,q_m1} by 1 (A MSB replicated).
  - step_cnt++.
- RUN, start=0, done=0, step_cnt=N: no register change (idle wait for done).
- RUN, start=0, done=1 (sampled):
  - product <= {A[N-1:0],Q}, prod_valid=1 for this cycle only, state=HOLD. No Booth step on this edge.
  - If step_cnt<N, also set seq_err=1: early done, and product holds the partial value.
- HOLD: prod_valid returns to 0 the next cycle. done is ignored; only start leaves HOLD.
- IDLE: done is ignored, no stepping.
- Latency with the paired controller:
  - Start is released before edge 1.
  - Steps occur on edges 1..N.
  - The controller raises done at edge N+1.
  - Capture and prod_valid occur at edge N+2.
- Width rule: true product range is [-2^(2N-2)+2^(N-1), 2^(2N-2)]. It always fits in 2N signed bits, so there is no overflow output.

Decomposition:
- Shared package holds:
  - the N default (6);
  - the state enum IDLE/RUN/HOLD;
  - the derived widths (2N, N+1, step_cnt width).
- Sub-module booth_step: purely combinational single iteration.
  - Inputs: {A,Q,q_m1}, M.
  - Output: next {A,Q,q_m1}.
- The top level holds the registers, FSM, step counter and error check.

Test Plan:
- Reset mid-RUN (rst_n low at step 3) -> product=0, prod_valid=0, seq_err=0 immediately, asynchronously; no capture afterwards without a new start.
- Paired with the control unit, N=6, M=5, Q=-3 -> at edge 8 after start release: product=12'hFF1 (-15), prod_valid high exactly 1 cycle, seq_err=0.
- Corner operands, each run separately:
  - M=-32, Q=-32 -> product=12'h400 (+1024).
  - M=31, Q=-32 -> product=12'hC20 (-992).
  - M=0, Q=-17 -> product=0.
- Restart: second start at step 3 with M=7, Q=7 -> one prod_valid only, product=12'h031 (49), seq_err=0.
- Early done: stub drives done=1 after 4 steps with M=3, Q=3 -> prod_valid pulses, seq_err=1 held until the next start; the next full run clears seq_err.
- HOLD stability: keep done high 10 cycles after capture and toggle the operand inputs -> product unchanged, no further prod_valid.
